// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared types and sizes for the register-file write arbiter
// Widths, zero-register index, round-robin pointer enum and the writeback request struct.
package regfile_arb_pkg;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 64;
   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

   typedef enum logic {
      PRI_A = 1'b0,
      PRI_B = 1'b1
   } rr_ptr_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback sources, stall and register-file write port bundle
// master = writeback sources and register file side, slave = arbiter.
interface regfile_write_arbiter_if;
   import regfile_arb_pkg::*;

   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              wr_stall;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [15:0]       conflict_cnt;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data, wr_stall,
      input  a_ready, b_ready, wr_en, wr_addr, wr_data, conflict_cnt
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, wr_stall,
      output a_ready, b_ready, wr_en, wr_addr, wr_data, conflict_cnt
   );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with same-address priority to the older source
// req[0]/gnt[0] is source A, req[1]/gnt[1] is source B; holds the round-robin pointer.
module rr_arb2
   import regfile_arb_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       same_addr,
   input  logic       stall,
   output logic [1:0] gnt
);
   rr_ptr_t r_rr_ptr;
   logic    w_rr_turn;

   // Only a contended, different-address cycle counts as a round-robin decision.
   assign w_rr_turn = req[0] && req[1] && !same_addr && !stall;

   always_comb begin
      gnt = 2'b00;
      if (reset_n && !stall) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (same_addr || r_rr_ptr == PRI_B) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr_ptr <= PRI_A;
      end else if (w_rr_turn) begin
         r_rr_ptr <= (r_rr_ptr == PRI_A) ? PRI_B : PRI_A;
      end
   end
endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between ALU (A) and load (B) writeback
// Optional saturating conflict counter built only when CONFLICT_CNT_EN is defined.
module regfile_write_arbiter
   import regfile_arb_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   regfile_write_arbiter_if.slave  wb
);
   logic [1:0]        w_gnt;
   logic              w_same_addr;
   logic              w_xfer;
   wb_req_t           w_sel;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [DATA_W-1:0] r_wr_data;

   assign w_same_addr = (wb.a_addr == wb.b_addr);

   rr_arb2 u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       ({wb.b_valid, wb.a_valid}),
      .same_addr (w_same_addr),
      .stall     (wb.wr_stall),
      .gnt       (w_gnt)
   );

   assign wb.a_ready = w_gnt[0];
   assign wb.b_ready = w_gnt[1];
   assign w_xfer     = |w_gnt;

   always_comb begin
      w_sel.addr = wb.a_addr;
      w_sel.data = wb.a_data;
      if (w_gnt[1]) begin
         w_sel.addr = wb.b_addr;
         w_sel.data = wb.b_data;
      end
   end

   // Zero-register writes are consumed but never reach the decoder.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= w_xfer && (w_sel.addr != ZERO_REG);
         if (w_xfer) begin
            r_wr_addr <= w_sel.addr;
            r_wr_data <= w_sel.data;
         end
      end
   end

   assign wb.wr_en   = r_wr_en;
   assign wb.wr_addr = r_wr_addr;
   assign wb.wr_data = r_wr_data;

`ifdef CONFLICT_CNT_EN
   logic [15:0] r_conflict_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_conflict_cnt <= 16'd0;
      end else if (wb.a_valid && wb.b_valid && !wb.wr_stall && r_conflict_cnt != 16'hFFFF) begin
         r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
   end

   assign wb.conflict_cnt = r_conflict_cnt;
`else
   assign wb.conflict_cnt = 16'd0;
`endif
endmodule
